led_chase_monitor: RTL

//  Receive-side checker for the 8-LED one-hot chaser bus. Samples the LED bus and locks onto the lit position.

---
 rtl/led_chase_monitor.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/led_chase_monitor.sv
// rtl/led_chase_monitor.sv - receive-side checker for the 8-LED one-hot chaser bus
module led_chase_monitor #(
    parameter int DEBOUNCE  = 2,
    parameter int BLANK_MAX = 1024,
    parameter int DW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [7:0]    led_in,
    output logic [2:0]    pos,
    output logic          locked,
    output logic          step,
    output logic [DW-1:0] dwell,
    output logic [7:0]    lap,
    output logic          fault,
    output logic [1:0]    err_code
);

    localparam int BW = $clog2(BLANK_MAX + 1);
    localparam logic [3:0]    DEB  = DEBOUNCE[3:0];
    localparam logic [BW-1:0] BMAX = BLANK_MAX[BW-1:0];

    typedef enum logic [1:0] {
        ST_SEEK  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [7:0]    led_r, led_prev;
    logic [3:0]    seek_cnt, seek_n;
    logic [3:0]    cand_cnt, cand_n;
    logic [BW-1:0] blank_cnt, blank_n;
    logic [DW-1:0] dwell_cnt, dwell_cnt_n;
    logic [2:0]    pos_n;
    logic [DW-1:0] dwell_n;
    logic [7:0]    lap_n;
    logic [1:0]    err_n;
    logic          step_n;

    logic          is_blank, is_multi, is_onehot;
    logic [2:0]    idx;
    logic [2:0]    pos_inc;
    logic [3:0]    seek_inc, cand_inc;
    logic [BW-1:0] blank_inc;
    logic [DW-1:0] dwell_inc;

    assign is_blank  = (led_r == 8'd0);
    assign is_multi  = |(led_r & (led_r - 8'd1));
    assign is_onehot = !is_blank && !is_multi;
    assign pos_inc   = pos + 3'd1;
    assign seek_inc  = (seek_cnt == '1)  ? seek_cnt  : seek_cnt + 4'd1;
    assign cand_inc  = (cand_cnt == '1)  ? cand_cnt  : cand_cnt + 4'd1;
    assign blank_inc = (blank_cnt == '1) ? blank_cnt : blank_cnt + 1'b1;
    assign dwell_inc = (dwell_cnt == '1) ? dwell_cnt : dwell_cnt + 1'b1;

    assign locked = (state == ST_TRACK);
    assign fault  = (state == ST_FAULT);

    // Encode the lit position of the sampled bus (only meaningful when one-hot)
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (led_r[i]) idx = 3'(i);
        end
    end

    // Next-state and next-value logic: clr, then enable gating, then per-state behaviour
    always_comb begin
        state_n     = state;
        seek_n      = seek_cnt;
        cand_n      = cand_cnt;
        blank_n     = blank_cnt;
        dwell_cnt_n = dwell_cnt;
        pos_n       = pos;
        dwell_n     = dwell;
        lap_n       = lap;
        err_n       = err_code;
        step_n      = 1'b0;

        if (clr) begin
            state_n     = ST_SEEK;
            seek_n      = '0;
            cand_n      = '0;
            blank_n     = '0;
            dwell_cnt_n = '0;
            err_n       = 2'b00;
        end else if (en) begin
            case (state)
                ST_SEEK: begin
                    if (is_onehot) begin
                        seek_n = (led_r == led_prev) ? seek_inc : 4'd1;
                        if (seek_n >= DEB) begin
                            pos_n       = idx;
                            dwell_cnt_n = '0;
                            cand_n      = '0;
                            blank_n     = '0;
                            seek_n      = '0;
                            state_n     = ST_TRACK;
                        end
                    end else begin
                        seek_n = '0;
                    end
                end
                ST_TRACK: begin
                    dwell_cnt_n = dwell_inc;
                    if (is_multi) begin
                        state_n = ST_FAULT;
                        err_n   = 2'b01;
                    end else if (is_blank) begin
                        cand_n  = '0;
                        blank_n = blank_inc;
                        if (blank_n >= BMAX) begin
                            state_n = ST_FAULT;
                            err_n   = 2'b11;
                        end
                    end else if (idx == pos) begin
                        cand_n  = '0;
                        blank_n = '0;
                    end else if (idx == pos_inc) begin
                        blank_n = '0;
                        cand_n  = cand_inc;
                        if (cand_n >= DEB) begin
                            pos_n       = pos_inc;
                            step_n      = 1'b1;
                            dwell_n     = dwell_inc;
                            dwell_cnt_n = '0;
                            cand_n      = '0;
                            if (pos == 3'd7) lap_n = lap + 8'd1;
                        end
                    end else begin
                        state_n = ST_FAULT;
                        err_n   = 2'b10;
                    end
                end
                ST_FAULT: begin
                    state_n = ST_FAULT;
                end
                default: begin
                    state_n = ST_SEEK;
                end
            endcase
        end
    end

    // Bus sampling runs every edge so the pipeline is fresh when en returns
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r    <= 8'd0;
            led_prev <= 8'd0;
        end else begin
            led_r    <= led_in;
            led_prev <= led_r;
        end
    end

    // State register and all tracked counters/outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SEEK;
            seek_cnt  <= '0;
            cand_cnt  <= '0;
            blank_cnt <= '0;
            dwell_cnt <= '0;
            pos       <= 3'd0;
            dwell     <= '0;
            lap       <= 8'd0;
            err_code  <= 2'b00;
            step      <= 1'b0;
        end else begin
            state     <= state_n;
            seek_cnt  <= seek_n;
            cand_cnt  <= cand_n;
            blank_cnt <= blank_n;
            dwell_cnt <= dwell_cnt_n;
            pos       <= pos_n;
            dwell     <= dwell_n;
            lap       <= lap_n;
            err_code  <= err_n;
            step      <= step_n;
        end
    end

endmodule
